// File: rtl/formula_nested_sqrt_fsm.sv
// Nested-root sequencer res = isqrt(x0 + isqrt(x1 + ... isqrt(x[N-1]))) over one shared isqrt unit.
// Latency N_ARGS*(L+1)+1 cycles from acceptance; arg_rdy low while busy, no queuing of arguments.
module formula_nested_sqrt_fsm #(
    parameter int N_ARGS = 3,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arg_vld,
    output logic                arg_rdy,
    input  logic [N_ARGS*W-1:0] args,
    output logic                res_vld,
    output logic [W-1:0]        res,
    output logic                res_ovf,
    output logic                isqrt_x_vld,
    output logic [W-1:0]        isqrt_x,
    input  logic                isqrt_y_vld,
    input  logic [W/2-1:0]      isqrt_y
);

    localparam int KW = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(N_ARGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q [N_ARGS];
    logic [W-1:0]   x_d [N_ARGS];
    logic [KW-1:0]  k_q, k_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   res_q, res_d;
    logic           res_ovf_q, res_ovf_d;
    logic           res_vld_q, res_vld_d;

    logic [W-1:0]   x_k;
    logic [W:0]     sum;

    assign x_k = x_q[k_q];
    // The extra bit of the sum is the carry that marks a wrapped partial sum.
    assign sum = {1'b0, x_k} + {1'b0, acc_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
            res_vld_q <= res_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        x_q <= x_d;
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        k_d       = k_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        res_vld_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arg_vld) begin
                    for (int i = 0; i < N_ARGS; i++) begin
                        x_d[i] = args[i*W +: W];
                    end
                    k_d     = K_TOP;
                    ovf_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (k_q != K_TOP && sum[W]) begin
                    ovf_d = 1'b1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (isqrt_y_vld) begin
                    if (k_q != '0) begin
                        acc_d   = {{(W/2){1'b0}}, isqrt_y};
                        k_d     = k_q - KW'(1);
                        state_d = S_ISSUE;
                    end else begin
                        res_d     = {{(W/2){1'b0}}, isqrt_y};
                        res_ovf_d = ovf_q;
                        res_vld_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arg_rdy     = rst && (state_q == S_IDLE);
        isqrt_x_vld = (state_q == S_ISSUE);
        isqrt_x     = (k_q == K_TOP) ? x_k : sum[W-1:0];
    end

    assign res_vld = res_vld_q;
    assign res     = res_q;
    assign res_ovf = res_ovf_q;

endmodule

// File: tb/tb_formula_nested_sqrt_fsm.sv
// Bench for formula_nested_sqrt_fsm: three parameterisations share one behavioural isqrt of latency L.
module tb_formula_nested_sqrt_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   av;
    logic [159:0] a_bus;

    logic rdy3, rv3, ovf3, xv3;  logic [31:0] res3, x3;
    logic rdy1, rv1, ovf1, xv1;  logic [15:0] res1, x1;
    logic rdy5, rv5, ovf5, xv5;  logic [31:0] res5, x5;

    int          sel = 0;
    int          L = 1;
    int          cyc = 0;
    int          cnt = 0;
    logic [15:0] yv = '0;
    logic        stray = 1'b0;
    logic [15:0] stray_y = '0;
    logic        y_vld;
    logic [15:0] y;
    logic [31:0] req_q [$];

    logic        x_vld_m, rdy_m, rv_m, ovf_m;
    logic [31:0] x_m, res_m;

    int          nvec = 0;
    int          nfail = 0;
    int          t0, tres, cur_n;
    logic [31:0] exp_res;
    logic        exp_ovf;
    logic [31:0] exp_req [16];

    formula_nested_sqrt_fsm #(.N_ARGS(3), .W(32)) dut3 (
        .clk(clk), .rst(rst), .arg_vld(av[0]), .arg_rdy(rdy3), .args(a_bus[95:0]),
        .res_vld(rv3), .res(res3), .res_ovf(ovf3), .isqrt_x_vld(xv3), .isqrt_x(x3),
        .isqrt_y_vld(y_vld), .isqrt_y(y));
    formula_nested_sqrt_fsm #(.N_ARGS(1), .W(16)) dut1 (
        .clk(clk), .rst(rst), .arg_vld(av[1]), .arg_rdy(rdy1), .args(a_bus[15:0]),
        .res_vld(rv1), .res(res1), .res_ovf(ovf1), .isqrt_x_vld(xv1), .isqrt_x(x1),
        .isqrt_y_vld(y_vld), .isqrt_y(y[7:0]));
    formula_nested_sqrt_fsm #(.N_ARGS(5), .W(32)) dut5 (
        .clk(clk), .rst(rst), .arg_vld(av[2]), .arg_rdy(rdy5), .args(a_bus),
        .res_vld(rv5), .res(res5), .res_ovf(ovf5), .isqrt_x_vld(xv5), .isqrt_x(x5),
        .isqrt_y_vld(y_vld), .isqrt_y(y));

    function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
        longint r = 0;
        for (int b = 15; b >= 0; b--) begin
            longint c = r + (longint'(1) << b);
            if (c * c <= longint'(x)) r = c;
        end
        return r[15:0];
    endfunction

    function automatic int nn(input int s);
        return (s == 0) ? 3 : ((s == 1) ? 1 : 5);
    endfunction

    function automatic int ww(input int s);
        return (s == 1) ? 16 : 32;
    endfunction

    always_comb begin
        x_vld_m = xv3 | xv1 | xv5;
        case (sel)
            1:       begin rdy_m = rdy1; rv_m = rv1; ovf_m = ovf1; res_m = {16'h0, res1}; x_m = {16'h0, x1}; end
            2:       begin rdy_m = rdy5; rv_m = rv5; ovf_m = ovf5; res_m = res5; x_m = x5; end
            default: begin rdy_m = rdy3; rv_m = rv3; ovf_m = ovf3; res_m = res3; x_m = x3; end
        endcase
    end

    // Shared isqrt: answer arrives exactly L cycles after the request strobe.
    assign y_vld = (cnt == 1) || stray;
    assign y     = stray ? stray_y : yv;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            cnt <= 0;
        end else if (x_vld_m) begin
            cnt <= L;
            yv  <= isqrt_ref(x_m);
            req_q.push_back(x_m);
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: evaluate the nested formula innermost-first with wrapping W-bit sums.
    task automatic ref_formula(input logic [159:0] a, input int n, input int w);
        longint mask = (longint'(1) << w) - 1;
        longint acc = 0;
        longint s;
        logic [159:0] sh;
        exp_ovf = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            sh = a >> (i * w);
            s  = longint'(sh[63:0]) & mask;
            if (i != n - 1) begin
                s = s + acc;
                if (s > mask) exp_ovf = 1'b1;
                s = s & mask;
            end
            exp_req[n-1-i] = s[31:0];
            acc = longint'(isqrt_ref(s[31:0]));
        end
        exp_res = acc[31:0];
    endtask

    task automatic start(input int s, input logic [159:0] a, input int lat);
        int b = 0;
        sel = s;
        L = lat;
        cur_n = nn(s);
        ref_formula(a, cur_n, ww(s));
        while (!rdy_m && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("arg_rdy_before_start", {63'h0, rdy_m}, 64'h1);
        req_q.delete();
        a_bus = a;
        av[s] = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        av[s] = 1'b0;
        a_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic finish(input logic chk_req);
        int b = 0;
        @(negedge clk);
        while (!rv_m && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk("res_vld_seen", {63'h0, rv_m}, 64'h1);
        chk("latency", 64'(cyc - t0), 64'(cur_n * (L + 1) + 1));
        chk("res", {32'h0, res_m}, {32'h0, exp_res});
        chk("res_ovf", {63'h0, ovf_m}, {63'h0, exp_ovf});
        chk("arg_rdy_at_res_vld", {63'h0, rdy_m}, 64'h1);
        if (chk_req) begin
            chk("req_count", 64'(req_q.size()), 64'(cur_n));
            for (int i = 0; i < cur_n && i < req_q.size(); i++) begin
                chk("req_operand", {32'h0, req_q[i]}, {32'h0, exp_req[i]});
            end
        end
        tres = cyc;
        @(negedge clk);
        chk("res_vld_one_cycle", {63'h0, rv_m}, 64'h0);
        chk("res_hold", {32'h0, res_m}, {32'h0, exp_res});
    endtask

    initial begin
        logic [159:0] case1;
        int seen;
        case1 = {64'h0, 32'd81, 32'd7, 32'd12};
        rst = 1'b0;
        av = '0;
        a_bus = '0;
        repeat (2) @(negedge clk);
        chk("rst_arg_rdy", {63'h0, rdy3}, 64'h0);
        chk("rst_res_vld", {63'h0, rv3}, 64'h0);
        chk("rst_res", {32'h0, res3}, 64'h0);
        chk("rst_res_ovf", {63'h0, ovf3}, 64'h0);
        chk("rst_x_vld", {61'h0, xv3, xv1, xv5}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_arg_rdy", {61'h0, rdy3, rdy1, rdy5}, 64'h7);

        // basic case, then wrapping case
        start(0, case1, 1);
        finish(1);
        chk("case1_res", {32'h0, res_m}, 64'd4);
        start(0, {64'h0, 32'd1, 32'd0, 32'hFFFF_FFFF}, 1);
        finish(1);
        chk("ovf_case_flag", {63'h0, ovf_m}, 64'h1);

        // back-pressure: a second set held during busy is only taken at the res_vld cycle
        start(0, case1, 1);
        repeat (2) @(negedge clk);
        chk("busy_arg_rdy", {63'h0, rdy3}, 64'h0);
        a_bus = '0;
        av[0] = 1'b1;
        finish(1);
        av[0] = 1'b0;
        ref_formula('0, 3, 32);
        t0 = tres;
        finish(0);

        // stray isqrt strobe in IDLE, then long-latency run
        @(negedge clk);
        stray_y = 16'h1234;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_ignored_rdy", {63'h0, rdy3}, 64'h1);
        start(0, case1, 5);
        finish(1);
        chk("lat5_res", {32'h0, res_m}, 64'd4);

        // reset while waiting on isqrt
        start(0, case1, 3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midop_rst_arg_rdy", {63'h0, rdy3}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_arg_rdy", {63'h0, rdy3}, 64'h1);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (rv3) seen++;
        end
        chk("no_res_after_rst", 64'(seen), 64'h0);
        chk("res_after_rst", {32'h0, res3}, 64'h0);
        start(0, {64'h0, 32'd16, 32'd0, 32'd0}, 1);
        finish(1);

        // other parameterisations
        start(1, 160'hFFFF, 2);
        finish(1);
        chk("n1_res", {32'h0, res_m}, 64'd255);
        chk("n1_ovf", {63'h0, ovf_m}, 64'h0);
        start(2, 160'd256 << 128, 1);
        finish(1);
        chk("n5_res", {32'h0, res_m}, 64'd1);

        // randomized operations
        for (int i = 0; i < 12; i++) begin
            int s;
            logic [159:0] r;
            s = (i < 6) ? 0 : ((i < 9) ? 2 : 1);
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if (i % 2 == 1) r = r & {5{32'h0000_0FFF}};
            start(s, r, int'($urandom_range(1, 4)));
            finish(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
